// File: rtl/re_name_inflight_ctrl_pkg.sv
// Shared constants and types for the in-flight rename write controller.
package re_name_inflight_ctrl_pkg;

  // Rename tag width and commit width of the surrounding core.
  localparam int NAME_BITS       = 1;
  localparam int NR_COMMIT_PORTS = 2;

  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;
  localparam int MAX_INFLIGHT = 2 ** NAME_BITS;
  localparam int CNT_W        = NAME_BITS + 1;
  // Width of "how many commit ports hit this entry" and of the widened sum.
  localparam int DEC_W        = $clog2(NR_COMMIT_PORTS + 1);
  localparam int SUM_W        = CNT_W + DEC_W;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/re_name_inflight_ctrl_cnt.sv
// One 32-entry bank of in-flight write counters: one increment port, one
// decrement per commit port, net delta per cycle, saturate-at-zero with a
// sticky underflow flag. Also exposes counts with only this cycle's
// decrements applied, so the issue side can see slots freed by commits.
module re_name_inflight_cnt
  import re_name_inflight_ctrl_pkg::*;
#(
  parameter bit ZERO_ENTRY0 = 1'b0
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                clear_i,
  input  logic                                inc_valid_i,
  input  logic [REG_ADDR_W-1:0]               inc_idx_i,
  input  logic [NR_COMMIT_PORTS-1:0]          dec_valid_i,
  input  logic [NR_COMMIT_PORTS*REG_ADDR_W-1:0] dec_idx_i,
  output logic [NUM_REGS-1:0][CNT_W-1:0]      cnt_o,
  output logic [NUM_REGS-1:0][CNT_W-1:0]      bypass_o,
  output logic                                err_o
);

  logic [CNT_W-1:0] cnt_reg  [NUM_REGS];
  logic [CNT_W-1:0] cnt_next [NUM_REGS];
  logic [NUM_REGS-1:0] underflow;
  logic err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_entry
      assign cnt_o[gi] = cnt_reg[gi];
      if (ZERO_ENTRY0 && gi == 0) begin : g_zero
        // Hard-wired register: never tracked, never flags.
        assign cnt_next[gi]  = '0;
        assign bypass_o[gi]  = '0;
        assign underflow[gi] = 1'b0;
      end else begin : g_cnt
        logic [DEC_W-1:0] dec_num;
        logic [SUM_W-1:0] cnt_ext;
        logic [SUM_W-1:0] plus_ext;
        logic [SUM_W-1:0] dec_ext;
        logic             inc_hit;

        // Count how many commit ports retire a write to this entry.
        always_comb begin
          dec_num = '0;
          for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            if (dec_valid_i[k] && dec_idx_i[k*REG_ADDR_W +: REG_ADDR_W] == REG_ADDR_W'(gi))
              dec_num = dec_num + DEC_W'(1);
          end
        end

        assign inc_hit  = inc_valid_i && (inc_idx_i == REG_ADDR_W'(gi));
        assign cnt_ext  = SUM_W'(cnt_reg[gi]);
        assign plus_ext = cnt_ext + SUM_W'(inc_hit);
        assign dec_ext  = SUM_W'(dec_num);

        // Net delta; going below zero clamps and reports.
        assign cnt_next[gi]  = (plus_ext >= dec_ext) ? CNT_W'(plus_ext - dec_ext) : '0;
        assign underflow[gi] = (plus_ext < dec_ext);
        assign bypass_o[gi]  = (cnt_ext >= dec_ext) ? CNT_W'(cnt_ext - dec_ext) : '0;
      end
    end
  endgenerate

  // Counter state; a flush wipes every count.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst_i || clear_i) cnt_reg[i] <= '0;
      else                  cnt_reg[i] <= cnt_next[i];
    end
  end

  // Underflow flag survives flushes; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i)                        err_reg <= 1'b0;
    else if (!clear_i && |underflow)  err_reg <= 1'b1;
  end

  // No entry may ever exceed the number of live rename tags.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        assert (cnt_reg[i] <= MAX_CNT);
      end
    end
  end

  assign err_o = err_reg;

endmodule

// File: rtl/re_name_inflight_ctrl.sv
// Issue gate for the 1-bit renaming stage: tracks in-flight writes per
// architectural register and holds issue when another write would alias a
// rename tag that is still live.
module re_name_inflight_ctrl
  import re_name_inflight_ctrl_pkg::*;
(
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  flush_i,
  input  logic                                  flush_unissued_instr_i,
  input  logic                                  issue_instr_valid_i,
  input  logic [REG_ADDR_W-1:0]                 issue_rd_i,
  input  logic                                  issue_rd_fpr_i,
  output logic                                  issue_ack_o,
  output logic                                  issue_instr_valid_o,
  input  logic                                  issue_ack_i,
  input  logic [NR_COMMIT_PORTS-1:0]            commit_ack_i,
  input  logic [NR_COMMIT_PORTS*REG_ADDR_W-1:0] commit_rd_i,
  input  logic [NR_COMMIT_PORTS-1:0]            commit_rd_fpr_i,
  output logic                                  stall_o,
  output logic                                  err_o
);

  ctrl_state_e           state_reg, state_next;
  logic [REG_ADDR_W-1:0] hold_rd_reg, hold_rd_next;
  logic                  hold_fpr_reg, hold_fpr_next;

  logic [NUM_REGS-1:0][CNT_W-1:0] gpr_cnt, gpr_byp, fpr_cnt, fpr_byp;
  logic [NR_COMMIT_PORTS-1:0]     gpr_dec, fpr_dec;
  logic                           issue_evt;
  logic                           rd_full;
  logic [CNT_W-1:0]               hold_cnt;
  logic                           gpr_err, fpr_err;

  genvar gi;
  generate
    for (gi = 0; gi < NR_COMMIT_PORTS; gi++) begin : g_commit_split
      assign gpr_dec[gi] = commit_ack_i[gi] && !commit_rd_fpr_i[gi];
      assign fpr_dec[gi] = commit_ack_i[gi] &&  commit_rd_fpr_i[gi];
    end
  endgenerate

  assign issue_evt = issue_ack_i && issue_instr_valid_o && !flush_unissued_instr_i;

  re_name_inflight_cnt #(.ZERO_ENTRY0(1'b1)) u_gpr_bank (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (flush_i),
    .inc_valid_i (issue_evt && !issue_rd_fpr_i),
    .inc_idx_i   (issue_rd_i),
    .dec_valid_i (gpr_dec),
    .dec_idx_i   (commit_rd_i),
    .cnt_o       (gpr_cnt),
    .bypass_o    (gpr_byp),
    .err_o       (gpr_err)
  );

  re_name_inflight_cnt #(.ZERO_ENTRY0(1'b0)) u_fpr_bank (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (flush_i),
    .inc_valid_i (issue_evt && issue_rd_fpr_i),
    .inc_idx_i   (issue_rd_i),
    .dec_valid_i (fpr_dec),
    .dec_idx_i   (commit_rd_i),
    .cnt_o       (fpr_cnt),
    .bypass_o    (fpr_byp),
    .err_o       (fpr_err)
  );

  // Offered rd is full only after this cycle's commits have freed slots.
  assign rd_full  = (issue_rd_fpr_i ? fpr_byp[issue_rd_i] : gpr_byp[issue_rd_i]) == MAX_CNT;
  // HOLD exit looks at the registered count of the captured register.
  assign hold_cnt = hold_fpr_reg ? fpr_cnt[hold_rd_reg] : gpr_cnt[hold_rd_reg];
  assign err_o    = gpr_err || fpr_err;

  // State and held-register capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ST_RUN;
      hold_rd_reg  <= '0;
      hold_fpr_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_rd_reg  <= hold_rd_next;
      hold_fpr_reg <= hold_fpr_next;
    end
  end

  // Next state and issue handshake gating.
  always_comb begin
    state_next          = state_reg;
    hold_rd_next        = hold_rd_reg;
    hold_fpr_next       = hold_fpr_reg;
    issue_instr_valid_o = 1'b0;
    issue_ack_o         = 1'b0;
    stall_o             = 1'b0;
    case (state_reg)
      ST_RUN: begin
        issue_instr_valid_o = issue_instr_valid_i && !rd_full;
        issue_ack_o         = issue_ack_i && issue_instr_valid_o;
        if (issue_instr_valid_i && rd_full) begin
          hold_rd_next  = issue_rd_i;
          hold_fpr_next = issue_rd_fpr_i;
          state_next    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        stall_o = 1'b1;
        if (hold_cnt < MAX_CNT) state_next = ST_RUN;
      end
      ST_FLUSH: begin
        state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
    if (flush_i) state_next = ST_FLUSH;
  end

endmodule

// File: tb/tb_re_name_inflight_ctrl.sv
// Directed bench for the in-flight rename write controller.
module tb_re_name_inflight_ctrl;
  import re_name_inflight_ctrl_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  logic flush_i;
  logic flush_unissued_instr_i;
  logic issue_instr_valid_i;
  logic [4:0] issue_rd_i;
  logic issue_rd_fpr_i;
  logic issue_ack_o;
  logic issue_instr_valid_o;
  logic issue_ack_i;
  logic [NR_COMMIT_PORTS-1:0] commit_ack_i;
  logic [NR_COMMIT_PORTS*5-1:0] commit_rd_i;
  logic [NR_COMMIT_PORTS-1:0] commit_rd_fpr_i;
  logic stall_o;
  logic err_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  re_name_inflight_ctrl dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .flush_i                (flush_i),
    .flush_unissued_instr_i (flush_unissued_instr_i),
    .issue_instr_valid_i    (issue_instr_valid_i),
    .issue_rd_i             (issue_rd_i),
    .issue_rd_fpr_i         (issue_rd_fpr_i),
    .issue_ack_o            (issue_ack_o),
    .issue_instr_valid_o    (issue_instr_valid_o),
    .issue_ack_i            (issue_ack_i),
    .commit_ack_i           (commit_ack_i),
    .commit_rd_i            (commit_rd_i),
    .commit_rd_fpr_i        (commit_rd_fpr_i),
    .stall_o                (stall_o),
    .err_o                  (err_o)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic offer(input logic [4:0] rd, input logic fpr, input logic ack);
    issue_instr_valid_i = 1'b1;
    issue_rd_i          = rd;
    issue_rd_fpr_i      = fpr;
    issue_ack_i         = ack;
  endtask

  task automatic idle_inputs();
    issue_instr_valid_i    = 1'b0;
    issue_ack_i            = 1'b0;
    commit_ack_i           = '0;
    commit_rd_fpr_i        = '0;
    commit_rd_i            = '0;
    flush_i                = 1'b0;
    flush_unissued_instr_i = 1'b0;
  endtask

  initial begin
    idle_inputs();
    issue_rd_i     = '0;
    issue_rd_fpr_i = 1'b0;
    rst_i          = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    #1;
    check_val("reset_valid_o", int'(issue_instr_valid_o), 0);
    check_val("reset_stall", int'(stall_o), 0);
    check_val("reset_err", int'(err_o), 0);
    check_val("reset_cnt_x5", int'(dut.u_gpr_bank.cnt_reg[5]), 0);

    // 1: two writes to x5, third offer is blocked
    offer(5'd5, 1'b0, 1'b1);
    #1;
    check_val("t1_issue1_valid", int'(issue_instr_valid_o), 1);
    check_val("t1_issue1_ack", int'(issue_ack_o), 1);
    step();
    check_val("t1_issue2_valid", int'(issue_instr_valid_o), 1);
    step();
    check_val("t1_cnt_x5", int'(dut.u_gpr_bank.cnt_reg[5]), 2);
    check_val("t1_third_valid", int'(issue_instr_valid_o), 0);
    check_val("t1_third_ack", int'(issue_ack_o), 0);
    step();
    check_val("t1_stall", int'(stall_o), 1);
    check_val("t1_hold_valid", int'(issue_instr_valid_o), 0);

    // 2: commit x5 on port 0 releases HOLD, then the third write issues
    commit_ack_i    = 2'b01;
    commit_rd_i     = {5'd0, 5'd5};
    commit_rd_fpr_i = 2'b00;
    step();
    commit_ack_i = '0;
    commit_rd_i  = '0;
    #1;
    check_val("t2_cnt_after_commit", int'(dut.u_gpr_bank.cnt_reg[5]), 1);
    step();
    check_val("t2_stall_released", int'(stall_o), 0);
    check_val("t2_valid", int'(issue_instr_valid_o), 1);
    check_val("t2_ack", int'(issue_ack_o), 1);
    step();
    check_val("t2_cnt_x5", int'(dut.u_gpr_bank.cnt_reg[5]), 2);
    idle_inputs();

    // 3: x0 is never counted and never stalls
    for (int i = 0; i < 5; i++) begin
      offer(5'd0, 1'b0, 1'b1);
      #1;
      check_val($sformatf("t3_x0_valid_%0d", i), int'(issue_instr_valid_o), 1);
      check_val($sformatf("t3_x0_stall_%0d", i), int'(stall_o), 0);
      step();
    end
    idle_inputs();
    #1;
    check_val("t3_cnt_x0", int'(dut.u_gpr_bank.cnt_reg[0]), 0);

    // flush_unissued suppresses counting
    offer(5'd9, 1'b0, 1'b1);
    flush_unissued_instr_i = 1'b1;
    step();
    idle_inputs();
    #1;
    check_val("fu_cnt_x9", int'(dut.u_gpr_bank.cnt_reg[9]), 0);

    // 4: f3 at 1, issue f3 plus two commits of f3 in one cycle
    offer(5'd3, 1'b1, 1'b1);
    step();
    check_val("t4_cnt_f3_pre", int'(dut.u_fpr_bank.cnt_reg[3]), 1);
    commit_ack_i    = 2'b11;
    commit_rd_i     = {5'd3, 5'd3};
    commit_rd_fpr_i = 2'b11;
    #1;
    check_val("t4_valid", int'(issue_instr_valid_o), 1);
    step();
    idle_inputs();
    #1;
    check_val("t4_cnt_f3", int'(dut.u_fpr_bank.cnt_reg[3]), 0);
    check_val("t4_err", int'(err_o), 0);

    // 5: commit x7 at zero -> sticky error
    commit_ack_i    = 2'b10;
    commit_rd_i     = {5'd7, 5'd0};
    commit_rd_fpr_i = 2'b00;
    step();
    idle_inputs();
    #1;
    check_val("t5_err", int'(err_o), 1);
    check_val("t5_cnt_x7", int'(dut.u_gpr_bank.cnt_reg[7]), 0);
    step();
    check_val("t5_err_sticky", int'(err_o), 1);

    // 6: flush while holding on x5
    offer(5'd5, 1'b0, 1'b1);
    #1;
    check_val("t6_blocked", int'(issue_instr_valid_o), 0);
    step();
    check_val("t6_stall", int'(stall_o), 1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    #1;
    check_val("t6_flush_valid", int'(issue_instr_valid_o), 0);
    check_val("t6_flush_ack", int'(issue_ack_o), 0);
    check_val("t6_flush_stall", int'(stall_o), 0);
    check_val("t6_cnt_x5", int'(dut.u_gpr_bank.cnt_reg[5]), 0);
    check_val("t6_err_kept", int'(err_o), 1);
    step();
    check_val("t6_resume_valid", int'(issue_instr_valid_o), 1);
    check_val("t6_resume_stall", int'(stall_o), 0);
    step();
    check_val("t6_cnt_x5_one", int'(dut.u_gpr_bank.cnt_reg[5]), 1);

    // Reset while holding
    step();
    check_val("rh_blocked", int'(issue_instr_valid_o), 0);
    step();
    check_val("rh_stall", int'(stall_o), 1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    check_val("rh_stall_after", int'(stall_o), 0);
    check_val("rh_cnt_x5", int'(dut.u_gpr_bank.cnt_reg[5]), 0);
    check_val("rh_err", int'(err_o), 0);
    check_val("rh_valid", int'(issue_instr_valid_o), 1);
    idle_inputs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
